sdram_round_arbiter: RTL and testbench
======================================

# sdram_round_arbiter

Shares the single `ip_sdram` access port between the V9958 clone (VDP) and one external requester, such as the cartridge-bus memory mapper or the debugger. Arbitration runs on the VDP's 4-phase `enable_state` rounds: one SDRAM access per round. The VDP has priority. An optional starvation guard keeps the external side from being locked out during heavy VDP command traffic. The block sits between `VDP`/external logic and `ip_sdram` in `tang20cart_msx`.

## Interface
- `STARVE_LIMIT`, default 4: consecutive rounds an external request may be denied before it is forced through (guard build only; range 1..7).
- `clk` in 1: system clock, 87.75 MHz.
- `reset` in 1: synchronous, active-high.
- `enable_state` in 2: VDP phase; advances by 1 per `clk`, wraps 3→0.
- `sdram_busy` in 1: SDRAM initialisation in progress.
- `vdp_rd_n` in 1: VDP read request, active-low.
- `vdp_wr_n` in 1: VDP write request, active-low.
- `vdp_address` in 17: VDP word/byte address.
- `vdp_wdata` in 8: VDP write data.
- `vdp_rdata` out 16: last VDP read data.
- `ext_req` in 1: external request, level.
- `ext_wr` in 1: 1 = write.
- `ext_address` in 23: external byte address.
- `ext_wdata` in 8: external write data.
- `ext_ack` out 1: one-cycle completion pulse.
- `ext_rdata` out 8: external read byte.
- `sdram_address` out 23: to `ip_sdram`.
- `sdram_is_write` out 1: to `ip_sdram`.
- `sdram_wdata` out 8: to `ip_sdram`.
- `sdram_rdata` in 16: from `ip_sdram`.

## Operation
- **States:** `S_INIT`, `S_IDLE`, `S_VDP`, `S_EXT`. The state is one-hot per round and changes only on the `enable_state==3` cycle.
- **`S_INIT`:** entered on reset. Held while `sdram_busy=1`. No grants, no acks. Leave to `S_IDLE` at the first `enable_state==3` cycle with `sdram_busy=0`.
- **Decision, made on `enable_state==3`:**
  - VDP access pending (`vdp_rd_n==0` or `vdp_wr_n==0`) and guard not tripped → `S_VDP`.
  - Else `ext_req==1` → `S_EXT`.
  - Else → `S_IDLE`.
- **Request latching:** the granted requester's address, write flag and data are registered into the `sdram_*` outputs on the same edge. They are held constant for the whole next round, phases 0..3.
- **Address mapping:**
  - VDP: `sdram_address = {6'b0, vdp_address}`, `sdram_is_write = ~vdp_wr_n`.
  - EXT: `sdram_address = ext_address`, `sdram_is_write = ext_wr`.
- **`S_IDLE`:** `sdram_is_write=0`; `sdram_address`/`sdram_wdata` keep their previous values. The resulting read is harmless.
- **Read capture, on the `enable_state==2` cycle of a granted read round:**
  - `S_VDP`: `vdp_rdata <= sdram_rdata`.
  - `S_EXT`: `ext_rdata <= ext_address_latched[0] ? sdram_rdata[15:8] : sdram_rdata[7:0]`.
  - Neither output changes in any other round.
- **`ext_ack`:** high for exactly the `enable_state==3` cycle that ends an `S_EXT` round, for reads and writes alike. The requester must hold `ext_req` and its operands until it sees `ext_ack`.
- **Back-to-back requests:** if `ext_req` is still high in the ack cycle, it counts as a new request and may be granted in the immediately following round.

## Timing
- **Reset values:** `sdram_address=0`, `sdram_is_write=0`, `sdram_wdata=0`, `vdp_rdata=0`, `ext_rdata=0`, `ext_ack=0`, state `S_INIT`, starve counter 0.
- **External latency:** `ext_req` rising before the `enable_state==3` edge of an uncontended round gives `ext_ack` 4 clocks later. Worst case without the guard is unbounded; with the guard it is `(STARVE_LIMIT+1)*4` clocks.
- **`vdp_rdata`:** valid from the cycle after phase 2 of the VDP round, earlier than the VDP's own phase-3 sampling.
- **`sdram_busy` rising after init:** finish the current round, emit any due ack, then enter `S_INIT`. A pending `ext_req` stays pending.
- **`reset` mid-round:** all outputs return to reset values on the next edge. A pending ext request is dropped without ack.
- **Simultaneous VDP and EXT requests:** VDP wins unless the guard has tripped.

## Configuration
- **`SDRAM_ARB_STARVE_GUARD_EN` defined:**
  - A 3-bit counter increments on each decision where `ext_req==1` but EXT is not granted, and clears on an EXT grant or `ext_req==0`.
  - When `count >= STARVE_LIMIT`, EXT wins the next decision over the VDP. The denied VDP request stays pending and is granted next round.
- **Undefined:** strict VDP priority; no counter logic.

## Structure
- Package `sdram_arb_pkg`:
  - state enum `S_INIT`/`S_IDLE`/`S_VDP`/`S_EXT`;
  - `c_phase_capture=2'd2`, `c_phase_decide=2'd3`;
  - `c_sdram_aw=23`.
- No sub-module. The starve counter is inline, under the macro.

## Test plan
- **Init gate:** `sdram_busy=1` for 40 clocks with `ext_req=1` → no `ext_ack`. First ack at phase 3 of the second round after busy falls.
- **VDP read:** `vdp_rd_n=0`, `vdp_address=17'h1ABCD`, `sdram_rdata=16'hBEEF` at phase 2 → `sdram_address=23'h01ABCD`, `vdp_rdata=16'hBEEF`, `ext_rdata` unchanged.
- **EXT byte select:**
  - `ext_address=23'h000011`, `sdram_rdata=16'h5AA5` → `ext_rdata=8'h5A`, single-cycle `ext_ack`.
  - `ext_address=23'h000010` → `ext_rdata=8'hA5`.
- **Contention:** VDP and EXT both request continuously.
  - Guard build, `STARVE_LIMIT=4`: EXT is granted once every 5 rounds.
  - No-guard build: zero EXT grants in 100 rounds.
- **EXT write:** `ext_wr=1`, `ext_wdata=8'h3C` → `sdram_is_write=1`, `sdram_wdata=8'h3C` for exactly 4 clocks, then `sdram_is_write=0` in the following idle round.
- **Reset mid-round:** `reset` asserted at phase 1 of an EXT round → all outputs 0 next cycle, no `ext_ack`, state `S_INIT`.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared state encoding, phase constants and byte-lane helper for the SDRAM round arbiter.
// Pure declarations; no logic and no latency of its own.
// Nothing here carries flow control; see sdram_round_arbiter for the handshake.
package sdram_arb_pkg;

  // One state per round, one-hot so each round kind is a single flop bit.
  typedef enum logic [3:0] {
    S_INIT = 4'b0001,
    S_IDLE = 4'b0010,
    S_VDP  = 4'b0100,
    S_EXT  = 4'b1000
  } arb_state_t;

  // Phase on which SDRAM read data is valid and captured.
  localparam logic [1:0] c_phase_capture = 2'd2;
  // Phase whose closing edge starts the next round and latches the winner.
  localparam logic [1:0] c_phase_decide  = 2'd3;

  localparam int c_sdram_aw = 23;
  localparam int c_vdp_aw   = 17;

  // The SDRAM returns a 16-bit word; byte addresses pick one lane by bit 0.
  function automatic logic [7:0] select_byte(input logic odd, input logic [15:0] word);
    return odd ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/sdram_round_arbiter.sv
// Shares the ip_sdram port between the VDP and one external requester, one access per 4-phase VDP round.
// Latency: grant on the phase-3 edge, operands held phases 0..3, reads captured at phase 2, ext_ack in the next phase-3 cycle.
// Backpressure: requests are levels; a losing requester simply stays pending, the external side holds ext_req until ext_ack.
// Build option: SDRAM_ARB_STARVE_GUARD_EN adds a denied-decision counter that forces an external grant after STARVE_LIMIT losses.
module sdram_round_arbiter
  import sdram_arb_pkg::*;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
#(
  parameter int STARVE_LIMIT = 4
)
`endif
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            enable_state,
  input  logic                  sdram_busy,
  input  logic                  vdp_rd_n,
  input  logic                  vdp_wr_n,
  input  logic [16:0]           vdp_address,
  input  logic [7:0]            vdp_wdata,
  output logic [15:0]           vdp_rdata,
  input  logic                  ext_req,
  input  logic                  ext_wr,
  input  logic [22:0]           ext_address,
  input  logic [7:0]            ext_wdata,
  output logic                  ext_ack,
  output logic [7:0]            ext_rdata,
  output logic [22:0]           sdram_address,
  output logic                  sdram_is_write,
  output logic [7:0]            sdram_wdata,
  input  logic [15:0]           sdram_rdata
);

  arb_state_t            state_q, state_d;
  arb_state_t            next_state;
  logic [c_sdram_aw-1:0] sdram_address_q, sdram_address_d;
  logic                  sdram_is_write_q, sdram_is_write_d;
  logic [7:0]            sdram_wdata_q, sdram_wdata_d;
  logic [15:0]           vdp_rdata_q, vdp_rdata_d;
  logic [7:0]            ext_rdata_q, ext_rdata_d;
  logic                  ext_ack_q, ext_ack_d;

  logic                  decide_now;
  logic                  capture_now;
  logic                  vdp_pending;
  logic                  ext_forced;

  assign decide_now  = (enable_state == c_phase_decide);
  assign capture_now = (enable_state == c_phase_capture);
  assign vdp_pending = ~vdp_rd_n | ~vdp_wr_n;

`ifdef SDRAM_ARB_STARVE_GUARD_EN
  localparam logic [2:0] c_starve_limit = 3'(STARVE_LIMIT);

  logic [2:0] starve_cnt_q, starve_cnt_d;
  logic       arbitrating;

  // Only real arbitration decisions (not init or busy rounds) age the external request.
  assign arbitrating = decide_now && !sdram_busy && (state_q != S_INIT);
  assign ext_forced  = ext_req && (starve_cnt_q >= c_starve_limit);

  // Count consecutive denied decisions; any grant or a dropped request starts over.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (arbitrating) begin
      if (!ext_req || (next_state == S_EXT)) begin
        starve_cnt_d = 3'd0;
      end else if (starve_cnt_q != 3'd7) begin
        starve_cnt_d = starve_cnt_q + 3'd1;
      end
    end
  end

  // Starve counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= 3'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  // Strict VDP priority: the external side never overrides a pending VDP access.
  assign ext_forced = 1'b0;
`endif

  // Winner of the round that starts on the coming phase-3 edge.
  always_comb begin
    next_state = S_IDLE;
    if (sdram_busy) begin
      next_state = S_INIT;
    end else if (state_q == S_INIT) begin
      // One empty round after init so the first grant is cleanly round-aligned.
      next_state = S_IDLE;
    end else if (vdp_pending && !ext_forced) begin
      next_state = S_VDP;
    end else if (ext_req) begin
      next_state = S_EXT;
    end
  end

  // Next-value logic: operands load on the decide phase, read data lands on the capture phase.
  always_comb begin
    state_d          = state_q;
    sdram_address_d  = sdram_address_q;
    sdram_is_write_d = sdram_is_write_q;
    sdram_wdata_d    = sdram_wdata_q;
    vdp_rdata_d      = vdp_rdata_q;
    ext_rdata_d      = ext_rdata_q;
    ext_ack_d        = 1'b0;

    if (capture_now && !sdram_is_write_q) begin
      if (state_q == S_VDP) begin
        vdp_rdata_d = sdram_rdata;
      end else if (state_q == S_EXT) begin
        ext_rdata_d = select_byte(sdram_address_q[0], sdram_rdata);
      end
    end

    // Registered here so the pulse occupies exactly the phase-3 cycle closing the EXT round.
    if (capture_now && (state_q == S_EXT)) begin
      ext_ack_d = 1'b1;
    end

    if (decide_now) begin
      state_d = next_state;
      case (next_state)
        S_VDP: begin
          sdram_address_d  = {{(c_sdram_aw - c_vdp_aw){1'b0}}, vdp_address};
          sdram_is_write_d = ~vdp_wr_n;
          sdram_wdata_d    = vdp_wdata;
        end
        S_EXT: begin
          sdram_address_d  = ext_address;
          sdram_is_write_d = ext_wr;
          sdram_wdata_d    = ext_wdata;
        end
        default: begin
          // Idle and init rounds issue a harmless read at the old address.
          sdram_is_write_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_INIT;
      sdram_address_q  <= '0;
      sdram_is_write_q <= 1'b0;
      sdram_wdata_q    <= 8'd0;
      vdp_rdata_q      <= 16'd0;
      ext_rdata_q      <= 8'd0;
      ext_ack_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      sdram_address_q  <= sdram_address_d;
      sdram_is_write_q <= sdram_is_write_d;
      sdram_wdata_q    <= sdram_wdata_d;
      vdp_rdata_q      <= vdp_rdata_d;
      ext_rdata_q      <= ext_rdata_d;
      ext_ack_q        <= ext_ack_d;
    end
  end

  assign sdram_address  = sdram_address_q;
  assign sdram_is_write = sdram_is_write_q;
  assign sdram_wdata    = sdram_wdata_q;
  assign vdp_rdata      = vdp_rdata_q;
  assign ext_rdata      = ext_rdata_q;
  assign ext_ack        = ext_ack_q;

endmodule

// File: tb/tb_sdram_round_arbiter.sv
// Bench for sdram_round_arbiter: the bench drives enable_state, models the SDRAM as a hashed word store,
// predicts each round's outcome from the arbitration rules, and scoreboards external responses on ext_ack.
module tb_sdram_round_arbiter;

  localparam int K_INIT = 0;
  localparam int K_IDLE = 1;
  localparam int K_VDP  = 2;
  localparam int K_EXT  = 3;
  localparam int LIM    = 4;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  enable_state;
  logic        sdram_busy;
  logic        vdp_rd_n;
  logic        vdp_wr_n;
  logic [16:0] vdp_address;
  logic [7:0]  vdp_wdata;
  logic [15:0] vdp_rdata;
  logic        ext_req;
  logic        ext_wr;
  logic [22:0] ext_address;
  logic [7:0]  ext_wdata;
  logic        ext_ack;
  logic [7:0]  ext_rdata;
  logic [22:0] sdram_address;
  logic        sdram_is_write;
  logic [7:0]  sdram_wdata;
  logic [15:0] sdram_rdata;

  logic        force_rd;
  logic [15:0] force_val;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [22:0] a);
    logic [31:0] h;
    h = 32'(a[22:1]) * 32'd40503 + 32'd4660;
    return h[23:8];
  endfunction

  function automatic logic [15:0] cur_word(input logic [22:0] a);
    return force_rd ? force_val : mem_word(a);
  endfunction

  function automatic logic [7:0] lane(input logic [22:0] a, input logic [15:0] w);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  // SDRAM stand-in: returns the word stored at whatever address the arbiter presents.
  assign sdram_rdata = cur_word(sdram_address);

  sdram_round_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .enable_state  (enable_state),
    .sdram_busy    (sdram_busy),
    .vdp_rd_n      (vdp_rd_n),
    .vdp_wr_n      (vdp_wr_n),
    .vdp_address   (vdp_address),
    .vdp_wdata     (vdp_wdata),
    .vdp_rdata     (vdp_rdata),
    .ext_req       (ext_req),
    .ext_wr        (ext_wr),
    .ext_address   (ext_address),
    .ext_wdata     (ext_wdata),
    .ext_ack       (ext_ack),
    .ext_rdata     (ext_rdata),
    .sdram_address (sdram_address),
    .sdram_is_write(sdram_is_write),
    .sdram_wdata   (sdram_wdata),
    .sdram_rdata   (sdram_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: what kind of round is running and what the port must show during it.
  int          m_kind;
  int          m_denied;
  logic [22:0] m_addr;
  logic        m_wr;
  logic [7:0]  m_wdata;
  logic [15:0] m_vdp_rdata;
  logic [7:0]  m_ext_rdata;
  logic [7:0]  sb_q[$];
  logic [7:0]  sb_exp;
  bit          ext_pending;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_kind      = K_INIT;
    m_denied    = 0;
    m_addr      = '0;
    m_wr        = 1'b0;
    m_wdata     = 8'd0;
    m_vdp_rdata = 16'd0;
    m_ext_rdata = 8'd0;
    sb_q.delete();
  endtask

  // Round outcome from the current request levels.
  task automatic model_decide();
    bit vdp_want;
    bit starving;
    int nk;
    vdp_want = !vdp_rd_n || !vdp_wr_n;
    starving = GUARD && ext_req && (m_denied >= LIM);
    if (sdram_busy)                nk = K_INIT;
    else if (m_kind == K_INIT)     nk = K_IDLE;
    else if (vdp_want && !starving) nk = K_VDP;
    else if (ext_req)              nk = K_EXT;
    else                           nk = K_IDLE;
    if (!sdram_busy && m_kind != K_INIT) begin
      if (!ext_req || nk == K_EXT) m_denied = 0;
      else if (m_denied < 7)       m_denied = m_denied + 1;
    end
    if (nk == K_VDP) begin
      m_addr  = {6'd0, vdp_address};
      m_wr    = !vdp_wr_n;
      m_wdata = vdp_wdata;
    end else if (nk == K_EXT) begin
      m_addr  = ext_address;
      m_wr    = ext_wr;
      m_wdata = ext_wdata;
      sb_q.push_back(ext_wr ? m_ext_rdata : lane(ext_address, cur_word(ext_address)));
    end else begin
      m_wr = 1'b0;
    end
    m_kind = nk;
  endtask

  task automatic model_capture();
    if (m_kind == K_VDP && !m_wr) m_vdp_rdata = cur_word(m_addr);
    if (m_kind == K_EXT && !m_wr) m_ext_rdata = lane(m_addr, cur_word(m_addr));
  endtask

  task automatic chk_outputs(input string tag, input bit exp_ack);
    chk({tag, "_sdram_address"},  32'(sdram_address),  32'(m_addr));
    chk({tag, "_sdram_is_write"}, 32'(sdram_is_write), 32'(m_wr));
    chk({tag, "_sdram_wdata"},    32'(sdram_wdata),    32'(m_wdata));
    chk({tag, "_vdp_rdata"},      32'(vdp_rdata),      32'(m_vdp_rdata));
    chk({tag, "_ext_rdata"},      32'(ext_rdata),      32'(m_ext_rdata));
    chk({tag, "_ext_ack"},        32'(ext_ack),        32'(exp_ack));
  endtask

  // Present phase 3 with the current request levels and take the decision edge.
  task automatic decide();
    model_decide();
    enable_state = 2'd3;
    @(posedge clk);
    #1;
  endtask

  // Walk phases 0..2 of the round just granted, checking all four cycles of it.
  task automatic round_body(output bit ack_seen);
    chk_outputs("ph0", 1'b0);
    for (int p = 0; p < 3; p++) begin
      enable_state = 2'(p);
      @(posedge clk);
      #1;
      if (p == 2) model_capture();
      chk_outputs($sformatf("ph%0d", p + 1), (p == 2) && (m_kind == K_EXT));
    end
    ack_seen = ext_ack;
  endtask

  task automatic ext_start(input logic [22:0] a, input bit wr, input logic [7:0] d);
    ext_address = a;
    ext_wr      = wr;
    ext_wdata   = d;
    ext_pending = 1'b1;
    ext_req     = 1'b1;
  endtask

  // The round that just ended acked the external requester if it was an EXT round.
  task automatic ext_retire();
    if (m_kind == K_EXT) begin
      ext_pending = 1'b0;
      ext_req     = 1'b0;
    end
  endtask

  task automatic vdp_set(input int kind, input logic [16:0] a, input logic [7:0] d);
    vdp_rd_n    = !(kind == 1);
    vdp_wr_n    = !(kind == 2);
    vdp_address = a;
    vdp_wdata   = d;
  endtask

  // Scoreboard monitor: each ext_ack retires the oldest expected external response.
  always @(negedge clk) begin
    if (ext_ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_ack actual=ack required=no_ack at %0t", $time);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("sb_ext_rdata", 32'(ext_rdata), 32'(sb_exp));
      end
    end
  end

  initial begin
    bit ack;
    int acks;

    reset       = 1'b1;
    enable_state = 2'd0;
    sdram_busy  = 1'b1;
    ext_req     = 1'b0;
    ext_wr      = 1'b0;
    ext_address = '0;
    ext_wdata   = 8'd0;
    force_rd    = 1'b0;
    force_val   = 16'd0;
    ext_pending = 1'b0;
    vdp_set(0, 17'd0, 8'd0);
    model_reset();

    // Reset values over one full phase cycle.
    for (int p = 0; p < 4; p++) begin
      enable_state = 2'(p);
      @(posedge clk);
      #1;
      chk_outputs("reset", 1'b0);
    end
    reset = 1'b0;
    round_body(ack);

    // Init gate: 40 busy clocks with a pending external read, no ack allowed.
    ext_start(23'h000123, 1'b0, 8'h00);
    for (int r = 0; r < 10; r++) begin
      decide();
      round_body(ack);
      chk("init_busy_no_ack", 32'(ack), 32'd0);
    end
    sdram_busy = 1'b0;
    for (int r = 1; r <= 2; r++) begin
      ext_retire();
      decide();
      round_body(ack);
      chk("init_first_ack_round", 32'(ack), 32'(r == 2));
    end

    // VDP read with a fixed SDRAM word.
    ext_retire();
    vdp_set(1, 17'h1ABCD, 8'h00);
    force_rd  = 1'b1;
    force_val = 16'hBEEF;
    decide();
    round_body(ack);
    chk("vdp_rd_sdram_address", 32'(sdram_address), 32'h0001ABCD);
    chk("vdp_rd_vdp_rdata", 32'(vdp_rdata), 32'h0000BEEF);
    vdp_set(0, 17'd0, 8'd0);

    // External byte-lane selection.
    force_val = 16'h5AA5;
    ext_start(23'h000011, 1'b0, 8'h00);
    decide();
    round_body(ack);
    chk("ext_odd_byte", 32'(ext_rdata), 32'h5A);
    chk("ext_odd_ack", 32'(ack), 32'd1);
    ext_retire();
    ext_start(23'h000010, 1'b0, 8'h00);
    decide();
    round_body(ack);
    chk("ext_even_byte", 32'(ext_rdata), 32'hA5);
    force_rd = 1'b0;

    // External write, then an idle round.
    ext_retire();
    ext_start(23'h0004C2, 1'b1, 8'h3C);
    decide();
    round_body(ack);
    chk("ext_wr_is_write", 32'(sdram_is_write), 32'd1);
    chk("ext_wr_wdata", 32'(sdram_wdata), 32'h3C);
    ext_retire();
    decide();
    round_body(ack);
    chk("idle_after_wr_is_write", 32'(sdram_is_write), 32'd0);

    // Contention: both sides request every round for 100 rounds.
    acks = 0;
    vdp_set(1, 17'h00F00, 8'h11);
    for (int r = 0; r < 100; r++) begin
      ext_retire();
      if (!ext_pending) ext_start(23'($urandom), 1'($urandom), 8'($urandom));
      decide();
      round_body(ack);
      acks += int'(ack);
    end
    chk("contention_ext_grants", 32'(acks), GUARD ? 32'd20 : 32'd0);

    // Randomised traffic including busy re-entry.
    for (int r = 0; r < 250; r++) begin
      ext_retire();
      if (!ext_pending && $urandom_range(1, 0) == 1)
        ext_start(23'($urandom), 1'($urandom), 8'($urandom));
      case ($urandom_range(3, 0))
        2:       vdp_set(1, 17'($urandom), 8'($urandom));
        3:       vdp_set(2, 17'($urandom), 8'($urandom));
        default: vdp_set(0, 17'($urandom), 8'($urandom));
      endcase
      sdram_busy = ($urandom_range(15, 0) == 0);
      decide();
      round_body(ack);
    end

    // Reset at phase 1 of an EXT round.
    ext_retire();
    sdram_busy = 1'b0;
    vdp_set(0, 17'd0, 8'd0);
    if (!ext_pending) ext_start(23'h000777, 1'b0, 8'h00);
    for (int r = 0; r < 3; r++) begin
      decide();
      if (m_kind == K_EXT) break;
      round_body(ack);
    end
    chk_outputs("rst_round_ph0", 1'b0);
    enable_state = 2'd0;
    @(posedge clk);
    #1;
    enable_state = 2'd1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    ext_pending = 1'b0;
    ext_req     = 1'b0;
    chk_outputs("rst_mid", 1'b0);
    reset = 1'b0;
    enable_state = 2'd2;
    @(posedge clk);
    #1;
    chk_outputs("rst_after", 1'b0);
    ext_start(23'h000042, 1'b0, 8'h00);
    for (int r = 1; r <= 2; r++) begin
      ext_retire();
      decide();
      round_body(ack);
      chk("rst_init_gate_ack", 32'(ack), 32'(r == 2));
    end

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
